vectored_irq_controller: RTL and testbench
==========================================

Name: vectored_irq_controller

Overview:
- Parametrised interrupt controller that replaces the single-target, sample-during-stall IRQ handling in the core.
- Latches interrupts in per-source pending bits, so a stalled multi-cycle instruction can no longer drop or repeat an IRQ.
- Per-source edge/level mode, mask and vector registers are memory-mapped on the data bus.
- Resolves fixed priority and drives a registered request/acknowledge/end-of-ISR handshake to the datapath's PC logic.

Parameters:
- NUM_IRQ, 5, number of interrupt sources (1..32).
- BASE_ADDR, 32'h0000_F000, byte address of register block; must be 256-byte aligned.
- ID_W, 3, width of irq_id; must be >= max(1, clog2(NUM_IRQ)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_sources  in  NUM_IRQ  interrupt lines, active-low, synchronous to clk.
- bus_addr  in  32  data bus byte address.
- bus_wdata  in  32  data bus write data.
- bus_mode  in  2  bus command: 00 idle, 01 read, 10 write, 11 idle.
- bus_rdata  out  32  read data; 0 when not selected.
- bus_sel  out  1  bus_addr within BASE_ADDR..BASE_ADDR+0xFF.
- irq_req  out  1  interrupt request to core.
- irq_id  out  ID_W  index of requested/in-service source.
- irq_target  out  32  vector (ISR address) of irq_id.
- irq_ack  in  1  core has taken the request (PC loaded with irq_target).
- irq_eoi  in  1  core executed end-of-ISR.
- in_isr  out  1  an interrupt is in service.

Behaviour:
- Reset (async, reset=0), all values:
  - Outputs: irq_req=0, irq_id=0, irq_target=0, in_isr=0.
  - Registers: MASK=0, MODE=0, PENDING=0, all VECTOR=0, edge-history register all-ones (inactive), FSM=IDLE.
  - Reset mid-request or mid-service aborts to these values.
- Register map (byte offset; word access only; bits >= NUM_IRQ read 0, writes ignored):
  - 0x00 MASK rw: 1 = enabled.
  - 0x04 MODE rw: 1 = edge, 0 = level.
  - 0x08 PENDING r; write-1-to-clear, edge sources only.
  - 0x0C STATUS r: bit0 irq_req, bit1 in_isr, bits[15:8] irq_id.
  - 0x10+4*i VECTOR[i] rw for i < NUM_IRQ; bits[1:0] forced 0.
  - Other offsets read 0, writes ignored.
- Bus timing:
  - Reads are combinational: bus_rdata valid in the same cycle as bus_mode=01 with bus_sel=1.
  - Writes take effect at the rising edge where bus_mode=10 and bus_sel=1.
- Pending logic:
  - Edge source i: PENDING[i] set at the clock after a cycle where prev[i]=1 and irq_sources[i]=0. prev is updated every cycle.
  - Level source i: PENDING[i] = registered ~irq_sources[i], updated every cycle; W1C and ack have no effect.
  - Edge set coinciding with a W1C or ack clear of the same bit: set wins.
  - Pending bits latch regardless of core stall.
- Priority: lowest index among (PENDING & MASK) wins.
- FSM IDLE:
  - If (PENDING & MASK) != 0: next cycle go to REQ with irq_req=1, irq_id=winner, irq_target=VECTOR[winner].
  - Request latency from input edge is 2 cycles.
- FSM REQ:
  - irq_id and irq_target are held stable; mask or vector writes do not withdraw or alter the committed request.
  - On irq_ack: next cycle go to SERVICE with irq_req=0, in_isr=1. PENDING[irq_id] clears if edge mode.
  - irq_eoi is ignored in this state.
- FSM SERVICE:
  - No nesting; new pendings accumulate.
  - On irq_eoi: next cycle go to IDLE with in_isr=0. A new request can be raised the cycle after that.
  - irq_ack is ignored in this state.
- irq_ack and irq_eoi asserted together: only the one valid in the current state acts.
- Level source still asserted at eoi: it re-requests, by design.

Test Plan:
- Reset defaults: hold reset=0 mid-REQ with irq_id=2 -> all outputs 0; STATUS reads 0; VECTOR[0..4] read 0.
- Edge latch through stall:
  - Setup: MASK=5'h01, MODE=5'h01, VECTOR[0]=0x100; pulse irq_sources[0] low for 1 cycle at cycle T.
  - Required: PENDING[0]=1 at T+1; irq_req=1, irq_target=0x100 at T+2.
  - Hold off irq_ack 10 cycles -> request held stable; ack -> PENDING=0, in_isr=1.
- Priority and hold-off:
  - Setup: MASK=5'h1F, MODE=5'h1F; sources 3 and 1 fall in the same cycle.
  - Required: irq_id=1; after ack and eoi -> irq_id=3 one cycle after in_isr drops.
- Masking:
  - Setup: MASK=0; edge on source 4 -> PENDING=5'h10, no irq_req.
  - Write MASK=5'h10 -> irq_req=1 next cycle.
  - W1C 5'h10 instead -> PENDING=0, no request.
- Level mode: source 2 level, held low through eoi -> immediate re-request with irq_id=2; release -> PENDING[2]=0 one cycle later.
- Set-vs-clear collision: W1C 0x01 in the same cycle as a new edge on source 0 -> PENDING[0] remains 1.

Source files
------------

// File: rtl/vectored_irq_controller_if.sv
// Data-bus and interrupt-handshake bundle between the core and the vectored IRQ controller.
interface vectored_irq_controller_if #(
    parameter int unsigned ID_W = 3
);
    logic [31:0]     bus_addr;
    logic [31:0]     bus_wdata;
    logic [1:0]      bus_mode;
    logic [31:0]     bus_rdata;
    logic            bus_sel;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     irq_target;
    logic            irq_ack;
    logic            irq_eoi;
    logic            in_isr;

    modport master (
        output bus_addr, bus_wdata, bus_mode, irq_ack, irq_eoi,
        input  bus_rdata, bus_sel, irq_req, irq_id, irq_target, in_isr
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_mode, irq_ack, irq_eoi,
        output bus_rdata, bus_sel, irq_req, irq_id, irq_target, in_isr
    );
endinterface

// File: rtl/vectored_irq_controller.sv
// Vectored interrupt controller: latched per-source pending bits, memory-mapped
// mask/mode/vector registers, fixed priority and a request/ack/eoi handshake.
module vectored_irq_controller #(
    parameter int unsigned NUM_IRQ   = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int unsigned ID_W      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_sources,
    vectored_irq_controller_if.slave bus
);

    localparam int unsigned WIDX_W = 6;
    localparam logic [WIDX_W-1:0] IDX_MASK   = WIDX_W'(0);
    localparam logic [WIDX_W-1:0] IDX_MODE   = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] IDX_PEND   = WIDX_W'(2);
    localparam logic [WIDX_W-1:0] IDX_STATUS = WIDX_W'(3);
    localparam int unsigned       IDX_VEC0   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pend_q, pend_d, prev_q;
    logic [31:0]        vec_q [NUM_IRQ];
    logic               req_q, req_d, isr_q, isr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        target_q, target_d;

    logic               sel_c, wr_c, rd_c, any_c;
    logic [WIDX_W-1:0]  widx_c;
    logic [NUM_IRQ-1:0] w1c_c, ack_clr_c, active_c;
    logic [ID_W-1:0]    win_c;
    logic [31:0]        win_vec_c, rdata_c;

    // Address decode: 256-byte window, word-aligned accesses only
    assign sel_c  = (bus.bus_addr[31:8] == BASE_ADDR[31:8]);
    assign widx_c = bus.bus_addr[7:2];
    assign wr_c   = sel_c && (bus.bus_addr[1:0] == 2'b00) && (bus.bus_mode == 2'b10);
    assign rd_c   = sel_c && (bus.bus_addr[1:0] == 2'b00) && (bus.bus_mode == 2'b01);

    assign active_c = pend_q & mask_q;
    assign any_c    = |active_c;

    // Edge bits: set beats clear; level bits simply mirror the inverted line
    always_comb begin
        w1c_c     = (wr_c && widx_c == IDX_PEND) ? bus.bus_wdata[NUM_IRQ-1:0] : '0;
        ack_clr_c = '0;
        pend_d    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr_c[i] = (state_q == ST_REQ) && bus.irq_ack && (id_q == ID_W'(i));
            if (mode_q[i]) begin
                pend_d[i] = (prev_q[i] & ~irq_sources[i]) |
                            (pend_q[i] & ~(w1c_c[i] | ack_clr_c[i]));
            end else begin
                pend_d[i] = ~irq_sources[i];
            end
        end
    end

    // Lowest enabled pending index wins
    always_comb begin
        win_c     = '0;
        win_vec_c = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active_c[i]) begin
                win_c     = ID_W'(i);
                win_vec_c = vec_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_c)       state_d = ST_REQ;
            ST_REQ:  if (bus.irq_ack) state_d = ST_SVC;
            ST_SVC:  if (bus.irq_eoi) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // The request id/vector is committed on leaving IDLE and held until the next one
    always_comb begin
        req_d    = (state_d == ST_REQ);
        isr_d    = (state_d == ST_SVC);
        id_d     = id_q;
        target_d = target_q;
        if (state_q == ST_IDLE && any_c) begin
            id_d     = win_c;
            target_d = win_vec_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= 1'b0;
            isr_q    <= 1'b0;
            id_q     <= '0;
            target_q <= '0;
            pend_q   <= '0;
            prev_q   <= '1;
        end else begin
            req_q    <= req_d;
            isr_q    <= isr_d;
            id_q     <= id_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            prev_q   <= irq_sources;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            mode_q <= '0;
            for (int i = 0; i < NUM_IRQ; i++) vec_q[i] <= '0;
        end else if (wr_c) begin
            if (widx_c == IDX_MASK) mask_q <= bus.bus_wdata[NUM_IRQ-1:0];
            if (widx_c == IDX_MODE) mode_q <= bus.bus_wdata[NUM_IRQ-1:0];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (widx_c == WIDX_W'(IDX_VEC0 + i)) vec_q[i] <= bus.bus_wdata & ~32'h3;
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (rd_c) begin
            case (widx_c)
                IDX_MASK:   rdata_c = 32'(mask_q);
                IDX_MODE:   rdata_c = 32'(mode_q);
                IDX_PEND:   rdata_c = 32'(pend_q);
                IDX_STATUS: rdata_c = {16'h0, 8'(id_q), 6'h0, isr_q, req_q};
                default: begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (widx_c == WIDX_W'(IDX_VEC0 + i)) rdata_c = vec_q[i];
                    end
                end
            endcase
        end
    end

    assign bus.bus_rdata  = rdata_c;
    assign bus.bus_sel    = sel_c;
    assign bus.irq_req    = req_q;
    assign bus.irq_id     = id_q;
    assign bus.irq_target = target_q;
    assign bus.in_isr     = isr_q;

endmodule

// File: tb/tb_vectored_irq_controller.sv
// Bench for vectored_irq_controller: directed scenarios then random traffic against a reference model.
module tb_vectored_irq_controller;

    localparam int unsigned N    = 5;
    localparam logic [31:0] BASE = 32'h0000_F000;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;

    int n_assert = 0;
    int n_fail   = 0;

    vectored_irq_controller_if #(.ID_W(3)) bus_if ();

    vectored_irq_controller #(.NUM_IRQ(N), .BASE_ADDR(BASE), .ID_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_sources (src),
        .bus         (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 request outstanding, 2 in service
    logic [N-1:0] m_mask, m_mode, m_pend, m_prev;
    logic [31:0]  m_vec [N];
    int           m_phase, m_id;
    logic [31:0]  m_tgt;

    task automatic model_reset();
        m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '1;
        for (int i = 0; i < N; i++) m_vec[i] = '0;
        m_phase = 0; m_id = 0; m_tgt = '0;
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h100) && (a[1:0] == 2'b00);
    endfunction

    task automatic model_update();
        int           off;
        bit           wr;
        logic [N-1:0] w1c, np, masked;
        if (!reset) begin
            model_reset();
            return;
        end
        wr  = (bus_if.bus_mode == 2'b10) && in_window(bus_if.bus_addr);
        off = int'(bus_if.bus_addr - BASE);
        w1c = (wr && off == 8) ? bus_if.bus_wdata[N-1:0] : '0;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                bit set, clr;
                set   = m_prev[i] && !src[i];
                clr   = w1c[i] || (m_phase == 1 && bus_if.irq_ack && m_id == i);
                np[i] = set || (m_pend[i] && !clr);
            end else begin
                np[i] = !src[i];
            end
        end
        masked = m_pend & m_mask;
        if (m_phase == 0 && masked != 0) begin
            for (int i = N - 1; i >= 0; i--) if (masked[i]) m_id = i;
            m_tgt   = m_vec[m_id];
            m_phase = 1;
        end else if (m_phase == 1 && bus_if.irq_ack) begin
            m_phase = 2;
        end else if (m_phase == 2 && bus_if.irq_eoi) begin
            m_phase = 0;
        end
        if (wr) begin
            if (off == 0) m_mask = bus_if.bus_wdata[N-1:0];
            if (off == 4) m_mode = bus_if.bus_wdata[N-1:0];
            if (off >= 16 && off < 16 + 4 * N) m_vec[(off - 16) / 4] = bus_if.bus_wdata & ~32'h3;
        end
        m_pend = np;
        m_prev = src;
    endtask

    function automatic logic [31:0] exp_rdata();
        int off;
        if (!(bus_if.bus_mode == 2'b01 && in_window(bus_if.bus_addr))) return '0;
        off = int'(bus_if.bus_addr - BASE);
        if (off == 0)  return 32'(m_mask);
        if (off == 4)  return 32'(m_mode);
        if (off == 8)  return 32'(m_pend);
        if (off == 12) return {16'h0, 8'(m_id), 6'h0, 1'(m_phase == 2), 1'(m_phase == 1)};
        if (off >= 16 && off < 16 + 4 * N) return m_vec[(off - 16) / 4];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("irq_req",    32'(bus_if.irq_req),  32'(m_phase == 1));
        chk("in_isr",     32'(bus_if.in_isr),   32'(m_phase == 2));
        chk("irq_id",     32'(bus_if.irq_id),   32'(m_id));
        chk("irq_target", bus_if.irq_target,    m_tgt);
        chk("bus_sel",    32'(bus_if.bus_sel),  32'(bus_if.bus_addr[31:8] == BASE[31:8]));
        chk("bus_rdata",  bus_if.bus_rdata,     exp_rdata());
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        bus_if.bus_addr  = BASE + off;
        bus_if.bus_wdata = data;
        bus_if.bus_mode  = 2'b10;
        tick();
        bus_if.bus_mode  = 2'b00;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        bus_if.bus_addr = BASE + off;
        bus_if.bus_mode = 2'b01;
        #1;
        chk(tag, bus_if.bus_rdata, exp);
        bus_if.bus_mode = 2'b00;
    endtask

    task automatic pulse(input int i);
        src[i] = 1'b0;
        tick();
        src[i] = 1'b1;
    endtask

    task automatic ack_eoi();
        bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
        bus_if.irq_eoi = 1'b1; tick(); bus_if.irq_eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        src   = '1;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_mode  = 2'b00;
        bus_if.irq_ack   = 1'b0;
        bus_if.irq_eoi   = 1'b0;
        model_reset();
        tick(); tick();
        reset = 1'b1;
        tick();

        // Reset aborts an outstanding request with id 2
        wr(32'h00, 32'h1F); wr(32'h04, 32'h1F); wr(32'h18, 32'h200);
        pulse(2); tick();
        chk("rst_pre_req", 32'(bus_if.irq_req), 32'h1);
        chk("rst_pre_id",  32'(bus_if.irq_id),  32'h2);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_req", 32'(bus_if.irq_req), 32'h0);
        chk("rst_tgt", bus_if.irq_target,   32'h0);
        tick();
        reset = 1'b1;
        tick();
        rd(32'h0C, 32'h0, "rst_status");
        for (int i = 0; i < N; i++) rd(32'h10 + 32'(4 * i), 32'h0, "rst_vector");

        // Edge latch with a stalled acknowledge
        wr(32'h00, 32'h01); wr(32'h04, 32'h01); wr(32'h10, 32'h100);
        pulse(0);
        rd(32'h08, 32'h1, "edge_pend_t1");
        tick();
        chk("edge_req_t2", 32'(bus_if.irq_req), 32'h1);
        chk("edge_tgt_t2", bus_if.irq_target,   32'h100);
        for (int k = 0; k < 10; k++) tick();
        chk("edge_hold_tgt", bus_if.irq_target, 32'h100);
        bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
        chk("edge_in_isr", 32'(bus_if.in_isr), 32'h1);
        rd(32'h08, 32'h0, "edge_pend_cleared");
        bus_if.irq_eoi = 1'b1; tick(); bus_if.irq_eoi = 1'b0;

        // Simultaneous sources 3 and 1: 1 first, then 3 after eoi
        wr(32'h00, 32'h1F); wr(32'h04, 32'h1F);
        src[3] = 1'b0; src[1] = 1'b0; tick(); src = '1;
        tick();
        chk("prio_first", 32'(bus_if.irq_id), 32'h1);
        ack_eoi();
        chk("prio_isr_drop", 32'(bus_if.in_isr), 32'h0);
        tick();
        chk("prio_second_req", 32'(bus_if.irq_req), 32'h1);
        chk("prio_second_id",  32'(bus_if.irq_id),  32'h3);
        ack_eoi();

        // Masked pending, then unmask; then masked pending cleared by W1C
        wr(32'h00, 32'h0);
        pulse(4); tick();
        rd(32'h08, 32'h10, "mask_pend");
        chk("mask_no_req", 32'(bus_if.irq_req), 32'h0);
        wr(32'h00, 32'h10);
        tick();
        chk("unmask_req", 32'(bus_if.irq_req), 32'h1);
        chk("unmask_id",  32'(bus_if.irq_id),  32'h4);
        ack_eoi();
        wr(32'h00, 32'h0);
        pulse(4); tick();
        wr(32'h08, 32'h10);
        rd(32'h08, 32'h0, "w1c_pend");
        wr(32'h00, 32'h10); tick();
        chk("w1c_no_req", 32'(bus_if.irq_req), 32'h0);

        // Level source held through eoi re-requests
        wr(32'h04, 32'h1B); wr(32'h00, 32'h04);
        src[2] = 1'b0; tick(); tick();
        chk("lvl_req_id", 32'(bus_if.irq_id), 32'h2);
        ack_eoi();
        tick();
        chk("lvl_rereq",    32'(bus_if.irq_req), 32'h1);
        chk("lvl_rereq_id", 32'(bus_if.irq_id),  32'h2);
        bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
        src[2] = 1'b1; tick();
        rd(32'h08, 32'h0, "lvl_release");
        bus_if.irq_eoi = 1'b1; tick(); bus_if.irq_eoi = 1'b0;
        tick();

        // W1C colliding with a new edge on the same source
        wr(32'h04, 32'h1F); wr(32'h00, 32'h0);
        pulse(0); tick();
        bus_if.bus_addr = BASE + 32'h08; bus_if.bus_wdata = 32'h1; bus_if.bus_mode = 2'b10;
        src[0] = 1'b0;
        tick();
        bus_if.bus_mode = 2'b00; src[0] = 1'b1;
        rd(32'h08, 32'h1, "collide_pend");
        wr(32'h08, 32'h1F); tick();

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int op, k;
            for (int i = 0; i < N; i++) src[i] = ($urandom_range(0, 5) != 0);
            bus_if.irq_ack = ($urandom_range(0, 3) == 0);
            bus_if.irq_eoi = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 9);
            k  = $urandom_range(0, 10);
            bus_if.bus_addr  = BASE + ((k < 9) ? 32'(4 * k) : (k == 9 ? 32'h80 : 32'h24));
            if ($urandom_range(0, 9) == 0) bus_if.bus_addr = bus_if.bus_addr + 32'h100;
            bus_if.bus_wdata = $urandom();
            bus_if.bus_mode  = (op < 5) ? 2'b00 : (op < 8 ? 2'b01 : 2'b10);
            tick();
        end
        bus_if.bus_mode = 2'b00;
        bus_if.irq_ack  = 1'b0;
        bus_if.irq_eoi  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
